// File: rtl/id_decode_rf.sv
// -----------------------------------------------------------------------------
// id_decode_rf
//
// Instruction-decode stage between instruction fetch and EX. It decodes the
// 6-bit opcode ISA, reads source operand values from an internal register file
// that is written by WB (with a same-cycle write-through bypass), and stalls IF
// for one bubble on a load-use hazard. It also supports EX back-pressure, branch
// flush and a sticky HALT state.
//
// Parameters
//   XLEN      datapath / register width (>= 16)
//   NREGS     register count: 8, 16 or 32
//   IMM_SEXT  1: imm16 sign-extended to XLEN, 0: zero-extended
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   if_valid/if_inst/if_pc/if_pc4
//                       instruction offered by IF, held by IF while id_ready=0
//   id_ready            ID accepts this cycle (combinational)
//   ex_ready            EX consumes ex_* this cycle
//   ex_flush            kill the instruction currently in ID
//   wb_we/wb_addr/wb_data
//                       register-file write port
//   ex_valid, ex_opcode, ex_rs_val, ex_rt_val, ex_dest, ex_imm, ex_pc, ex_pc4
//                       registered decoded instruction presented to EX
//   halted              sticky, set when HALT is issued to EX
//   illegal             one-cycle pulse after an undefined opcode is accepted
// -----------------------------------------------------------------------------
module id_decode_rf #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit IMM_SEXT = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [31:0]     if_pc,
    input  logic [31:0]     if_pc4,
    output logic            id_ready,

    input  logic            ex_ready,
    input  logic            ex_flush,

    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,

    output logic            ex_valid,
    output logic [5:0]      ex_opcode,
    output logic [XLEN-1:0] ex_rs_val,
    output logic [XLEN-1:0] ex_rt_val,
    output logic [AW-1:0]   ex_dest,
    output logic [XLEN-1:0] ex_imm,
    output logic [31:0]     ex_pc,
    output logic [31:0]     ex_pc4,
    output logic            halted,
    output logic            illegal
);

    // Opcodes with individual decode behaviour; 0x00-0x0B are handled as a range.
    localparam logic [5:0] OP_LAST_ALU = 6'h0B;
    localparam logic [5:0] OP_LDW      = 6'h0C;
    localparam logic [5:0] OP_STW      = 6'h0D;
    localparam logic [5:0] OP_BZ       = 6'h0E;
    localparam logic [5:0] OP_BEQ      = 6'h0F;
    localparam logic [5:0] OP_JR       = 6'h10;
    localparam logic [5:0] OP_HALT     = 6'h11;

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t state_q, state_d;

    // -------------------------------------------------------------------------
    // Instruction fields
    // -------------------------------------------------------------------------
    logic [5:0]      op;
    logic [AW-1:0]   rs_idx;
    logic [AW-1:0]   rt_idx;
    logic [AW-1:0]   rd_idx;
    logic [15:0]     imm16;
    logic [XLEN-1:0] imm_ext;

    assign op     = if_inst[31:26];
    assign rs_idx = if_inst[21 +: AW];
    assign rt_idx = if_inst[16 +: AW];
    assign rd_idx = if_inst[11 +: AW];
    assign imm16  = if_inst[15:0];

    generate
        if (IMM_SEXT) begin : g_sext
            assign imm_ext = XLEN'($signed(imm16));
        end else begin : g_zext
            assign imm_ext = XLEN'(imm16);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Opcode decode
    // -------------------------------------------------------------------------
    logic          dec_use_rs;
    logic          dec_use_rt;
    logic          dec_has_imm;
    logic [AW-1:0] dec_dest;
    logic          dec_halt;
    logic          dec_illegal;

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        dec_use_rs  = 1'b0;
        dec_use_rt  = 1'b0;
        dec_has_imm = 1'b0;
        dec_dest    = '0;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;

        if (op <= OP_LAST_ALU) begin
            dec_use_rs = 1'b1;
            if (!op[0]) begin
                // Register-register ALU: rd <- rs op rt
                dec_use_rt = 1'b1;
                dec_dest   = rd_idx;
            end else begin
                // Register-immediate ALU: rt <- rs op imm
                dec_has_imm = 1'b1;
                dec_dest    = rt_idx;
            end
        end else begin
            unique case (op)
                OP_LDW: begin
                    dec_use_rs  = 1'b1;
                    dec_has_imm = 1'b1;
                    dec_dest    = rt_idx;
                end
                OP_STW, OP_BEQ: begin
                    dec_use_rs  = 1'b1;
                    dec_use_rt  = 1'b1;
                    dec_has_imm = 1'b1;
                end
                OP_BZ: begin
                    dec_use_rs  = 1'b1;
                    dec_has_imm = 1'b1;
                end
                OP_JR: begin
                    dec_use_rs = 1'b1;
                end
                OP_HALT: begin
                    dec_halt = 1'b1;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Register file: r0 is never written and always reads as zero.
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this array is cleared on reset because software relies on
            // every register reading zero afterwards; that forces flops rather
            // than a RAM macro, which is acceptable at this size.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != '0)) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            regs[wb_addr] <= wb_data;
        end
    end

    // Operand read with write-through bypass from the WB port.
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    always_comb begin
        rs_val = regs[rs_idx];
        if (rs_idx == '0) begin
            rs_val = '0;
        end else if (wb_we && (wb_addr == rs_idx)) begin
            rs_val = wb_data;
        end

        rt_val = regs[rt_idx];
        if (rt_idx == '0) begin
            rt_val = '0;
        end else if (wb_we && (wb_addr == rt_idx)) begin
            rt_val = wb_data;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake and hazard detection
    // -------------------------------------------------------------------------
    // A load in EX produces its value too late for an instruction in ID that
    // reads the loaded register, so ID holds for one cycle.
    logic hazard;
    logic accept;

    assign hazard = ex_valid && (ex_opcode == OP_LDW) && (ex_dest != '0) &&
                    ((dec_use_rs && (rs_idx == ex_dest)) ||
                     (dec_use_rt && (rt_idx == ex_dest)));

    assign id_ready = ex_ready && !hazard && (state_q == S_RUN) && !reset;
    assign accept   = if_valid && id_ready && !ex_flush;

    // -------------------------------------------------------------------------
    // Run / halted state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:    if (accept && dec_halt) state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    assign halted = (state_q == S_HALTED);

    // -------------------------------------------------------------------------
    // ID/EX output register. With ex_ready low everything holds, which also
    // means a flush during back-pressure has no effect here.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_opcode <= '0;
            ex_rs_val <= '0;
            ex_rt_val <= '0;
            ex_dest   <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
            ex_pc4    <= '0;
        end else if (ex_ready) begin
            if (accept) begin
                ex_valid  <= !dec_illegal;
                ex_opcode <= op;
                ex_rs_val <= rs_val;
                ex_rt_val <= dec_use_rt ? rt_val : '0;
                ex_dest   <= dec_dest;
                ex_imm    <= dec_has_imm ? imm_ext : '0;
                ex_pc     <= if_pc;
                ex_pc4    <= if_pc4;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal <= 1'b0;
        end else begin
            illegal <= accept && dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_decode_rf.sv
module tb_id_decode_rf;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_valid;
    logic [31:0]     if_inst;
    logic [31:0]     if_pc;
    logic [31:0]     if_pc4;
    logic            ex_ready;
    logic            ex_flush;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    logic            id_ready;
    logic            ex_valid;
    logic [5:0]      ex_opcode;
    logic [XLEN-1:0] ex_rs_val;
    logic [XLEN-1:0] ex_rt_val;
    logic [AW-1:0]   ex_dest;
    logic [XLEN-1:0] ex_imm;
    logic [31:0]     ex_pc;
    logic [31:0]     ex_pc4;
    logic            halted;
    logic            illegal;

    // Second instance with zero-extended immediates, sharing all inputs.
    logic            z_id_ready;
    logic            z_ex_valid;
    logic [5:0]      z_ex_opcode;
    logic [XLEN-1:0] z_ex_rs_val;
    logic [XLEN-1:0] z_ex_rt_val;
    logic [AW-1:0]   z_ex_dest;
    logic [XLEN-1:0] z_ex_imm;
    logic [31:0]     z_ex_pc;
    logic [31:0]     z_ex_pc4;
    logic            z_halted;
    logic            z_illegal;

    always #5 clk = ~clk;

    id_decode_rf #(.XLEN(XLEN), .NREGS(NREGS), .IMM_SEXT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4),
        .id_ready(id_ready), .ex_ready(ex_ready), .ex_flush(ex_flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rs_val(ex_rs_val),
        .ex_rt_val(ex_rt_val), .ex_dest(ex_dest), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_pc4(ex_pc4), .halted(halted), .illegal(illegal)
    );

    id_decode_rf #(.XLEN(XLEN), .NREGS(NREGS), .IMM_SEXT(1'b0)) dut_z (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4),
        .id_ready(z_id_ready), .ex_ready(ex_ready), .ex_flush(ex_flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(z_ex_valid), .ex_opcode(z_ex_opcode), .ex_rs_val(z_ex_rs_val),
        .ex_rt_val(z_ex_rt_val), .ex_dest(z_ex_dest), .ex_imm(z_ex_imm),
        .ex_pc(z_ex_pc), .ex_pc4(z_ex_pc4), .halted(z_halted), .illegal(z_illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        chk;      // compare decoded fields (not for illegal opcodes)
        logic        e_valid;
        logic [5:0]  e_op;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [4:0]  e_dest;
        logic [31:0] e_imm;
        logic [31:0] e_imm_z;
        logic        e_ill;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Register state evolves across rows: r3=0x1234 (row 0), r7=0xAA (row 3),
        // r0 write dropped (row 4), r3=5 (row 9).
        vecs[0]  = '{i_type(6'h01, 5'd0, 5'd1, 16'h0010), 1'b1, 5'd3, 32'h1234,
                     1'b1, 1'b1, 6'h01, 32'h0, 32'h0, 5'd1, 32'h10, 32'h10, 1'b0};
        vecs[1]  = '{r_type(6'h00, 5'd3, 5'd3, 5'd5), 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 6'h00, 32'h1234, 32'h1234, 5'd5, 32'h0, 32'h0, 1'b0};
        vecs[2]  = '{i_type(6'h01, 5'd0, 5'd2, 16'hFFFF), 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 6'h01, 32'h0, 32'h0, 5'd2, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0};
        vecs[3]  = '{r_type(6'h02, 5'd7, 5'd3, 5'd8), 1'b1, 5'd7, 32'hAA,
                     1'b1, 1'b1, 6'h02, 32'hAA, 32'h1234, 5'd8, 32'h0, 32'h0, 1'b0};
        vecs[4]  = '{r_type(6'h06, 5'd0, 5'd7, 5'd9), 1'b1, 5'd0, 32'h5,
                     1'b1, 1'b1, 6'h06, 32'h0, 32'hAA, 5'd9, 32'h0, 32'h0, 1'b0};
        vecs[5]  = '{i_type(6'h0B, 5'd7, 5'd10, 16'h8001), 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 6'h0B, 32'hAA, 32'h0, 5'd10, 32'hFFFF_8001, 32'h0000_8001, 1'b0};
        vecs[6]  = '{i_type(6'h0D, 5'd7, 5'd3, 16'h0004), 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 6'h0D, 32'hAA, 32'h1234, 5'd0, 32'h4, 32'h4, 1'b0};
        vecs[7]  = '{i_type(6'h0E, 5'd3, 5'd7, 16'hFFFC), 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 6'h0E, 32'h1234, 32'h0, 5'd0, 32'hFFFF_FFFC, 32'h0000_FFFC, 1'b0};
        vecs[8]  = '{i_type(6'h10, 5'd7, 5'd3, 16'h1234), 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 6'h10, 32'hAA, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0};
        vecs[9]  = '{r_type(6'h04, 5'd3, 5'd7, 5'd31), 1'b1, 5'd3, 32'h5,
                     1'b1, 1'b1, 6'h04, 32'h5, 32'hAA, 5'd31, 32'h0, 32'h0, 1'b0};
        vecs[10] = '{i_type(6'h3F, 5'd3, 5'd7, 16'h1111), 1'b0, 5'd0, 32'h0,
                     1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{i_type(6'h0F, 5'd3, 5'd7, 16'h0008), 1'b0, 5'd0, 32'h0,
                     1'b1, 1'b1, 6'h0F, 32'h5, 32'hAA, 5'd0, 32'h8, 32'h8, 1'b0};

        // ---------------- reset ----------------
        reset    = 1'b1;
        if_valid = 1'b0;
        if_inst  = '0;
        if_pc    = '0;
        if_pc4   = '0;
        ex_ready = 1'b1;
        ex_flush = 1'b0;
        wb_we    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        #2;
        check("reset id_ready", 32'(id_ready), 32'd0);
        check("reset ex_valid", 32'(ex_valid), 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset illegal", 32'(illegal), 32'd0);
        check("reset ex_rs_val", ex_rs_val, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("post-reset id_ready", 32'(id_ready), 32'd1);

        // ---------------- table-driven decode ----------------
        for (int i = 0; i < 12; i++) begin
            if_valid = 1'b1;
            if_inst  = vecs[i].inst;
            if_pc    = 32'h100 + 32'(i) * 4;
            if_pc4   = 32'h104 + 32'(i) * 4;
            wb_we    = vecs[i].wbe;
            wb_addr  = vecs[i].wba;
            wb_data  = vecs[i].wbd;
            #1;
            check($sformatf("v%0d id_ready", i), 32'(id_ready), 32'd1);
            step();
            wb_we = 1'b0;
            check($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].e_ill));
            if (vecs[i].chk) begin
                check($sformatf("v%0d ex_opcode", i), 32'(ex_opcode), 32'(vecs[i].e_op));
                check($sformatf("v%0d ex_rs_val", i), ex_rs_val, vecs[i].e_rs);
                check($sformatf("v%0d ex_rt_val", i), ex_rt_val, vecs[i].e_rt);
                check($sformatf("v%0d ex_dest", i), 32'(ex_dest), 32'(vecs[i].e_dest));
                check($sformatf("v%0d ex_imm", i), ex_imm, vecs[i].e_imm);
                check($sformatf("v%0d zext ex_imm", i), z_ex_imm, vecs[i].e_imm_z);
                check($sformatf("v%0d ex_pc", i), ex_pc, 32'h100 + 32'(i) * 4);
                check($sformatf("v%0d ex_pc4", i), ex_pc4, 32'h104 + 32'(i) * 4);
            end
        end

        // ---------------- load-use hazard ----------------
        if_inst = i_type(6'h0C, 5'd1, 5'd4, 16'h0000);   // LDW r4, 0(r1)
        if_pc   = 32'h200;
        if_pc4  = 32'h204;
        #1;
        check("ldw id_ready", 32'(id_ready), 32'd1);
        step();
        check("ldw ex_opcode", 32'(ex_opcode), 32'h0C);
        check("ldw ex_dest", 32'(ex_dest), 32'd4);
        if_inst = r_type(6'h00, 5'd4, 5'd1, 5'd6);        // ADD r6, r4, r1
        if_pc   = 32'h204;
        if_pc4  = 32'h208;
        #1;
        check("hazard id_ready", 32'(id_ready), 32'd0);
        step();
        check("hazard bubble ex_valid", 32'(ex_valid), 32'd0);
        check("after bubble id_ready", 32'(id_ready), 32'd1);
        step();
        check("add after load ex_valid", 32'(ex_valid), 32'd1);
        check("add after load ex_opcode", 32'(ex_opcode), 32'h00);
        check("add after load ex_dest", 32'(ex_dest), 32'd6);
        check("add after load ex_pc", ex_pc, 32'h204);

        // ---------------- back-pressure, flush ignored while stalled ----------------
        if_inst  = r_type(6'h08, 5'd3, 5'd7, 5'd11);      // AND r11, r3, r7
        if_pc    = 32'h208;
        if_pc4   = 32'h20C;
        ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ex_flush = (c == 1);
            #1;
            check($sformatf("stall%0d id_ready", c), 32'(id_ready), 32'd0);
            step();
            check($sformatf("stall%0d ex_valid", c), 32'(ex_valid), 32'd1);
            check($sformatf("stall%0d ex_opcode", c), 32'(ex_opcode), 32'h00);
            check($sformatf("stall%0d ex_dest", c), 32'(ex_dest), 32'd6);
        end
        ex_ready = 1'b1;
        ex_flush = 1'b0;
        #1;
        check("release id_ready", 32'(id_ready), 32'd1);
        step();
        check("and ex_opcode", 32'(ex_opcode), 32'h08);
        check("and ex_rs_val", ex_rs_val, 32'h5);
        check("and ex_rt_val", ex_rt_val, 32'hAA);
        check("and ex_dest", 32'(ex_dest), 32'd11);

        // Flush kills the instruction in ID.
        if_inst  = r_type(6'h0A, 5'd3, 5'd3, 5'd12);      // XOR r12, r3, r3
        ex_flush = 1'b1;
        step();
        check("flush ex_valid", 32'(ex_valid), 32'd0);
        check("flush ex_dest hold", 32'(ex_dest), 32'd11);

        // ---------------- HALT ----------------
        if_inst = {6'h11, 26'd0};
        step();                                           // flushed HALT
        check("flushed halt halted", 32'(halted), 32'd0);
        check("flushed halt ex_valid", 32'(ex_valid), 32'd0);
        ex_flush = 1'b0;
        #1;
        check("halt id_ready", 32'(id_ready), 32'd1);
        step();
        check("halt halted", 32'(halted), 32'd1);
        check("halt ex_valid", 32'(ex_valid), 32'd1);
        check("halt ex_opcode", 32'(ex_opcode), 32'h11);
        check("halt ex_imm", ex_imm, 32'h0);
        if_inst = r_type(6'h00, 5'd3, 5'd3, 5'd13);
        wb_we   = 1'b1;
        wb_addr = 5'd20;
        wb_data = 32'hBEEF;
        #1;
        check("halted id_ready", 32'(id_ready), 32'd0);
        step();
        wb_we = 1'b0;
        check("halted ex_valid", 32'(ex_valid), 32'd0);
        check("halted sticky", 32'(halted), 32'd1);
        check("halted id_ready hold", 32'(id_ready), 32'd0);

        // ---------------- reset from HALTED ----------------
        #2;
        reset = 1'b1;
        #1;
        check("halt reset id_ready", 32'(id_ready), 32'd0);
        check("halt reset halted", 32'(halted), 32'd0);
        check("halt reset ex_valid", 32'(ex_valid), 32'd0);
        check("halt reset ex_opcode", 32'(ex_opcode), 32'd0);
        check("halt reset ex_pc", ex_pc, 32'd0);
        step();
        reset   = 1'b0;
        if_inst = r_type(6'h00, 5'd3, 5'd3, 5'd5);
        if_pc   = 32'h300;
        if_pc4  = 32'h304;
        #1;
        check("rerun id_ready", 32'(id_ready), 32'd1);
        step();
        check("rerun ex_valid", 32'(ex_valid), 32'd1);
        check("rerun ex_rs_val cleared rf", ex_rs_val, 32'd0);
        check("rerun ex_rt_val cleared rf", ex_rt_val, 32'd0);
        check("rerun ex_dest", 32'(ex_dest), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
